pipe_ctrl: RTL

Parametrised in-order pipeline skeleton that moves instruction tokens through DEPTH stages. Each token carries a payload, a destination register and a write flag. The block owns per-stage valid bits, elastic stall propagation with bubble collapse, younger-than-stage flushing, a forwarding-source lookup and a retire counter. It generalises the fixed five-stage valid/stall/flush register chain of the CPU, so core datapaths can read stage contents while control is centralised here.

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order token pipeline with elastic stalls, bubble collapse,
// younger-than-stage flush, forwarding-source lookup and a retire counter.
module pipe_ctrl #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 16,
   parameter int REGW  = 4,
   parameter int SELW  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_vld,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [REGW-1:0]        in_dst,
   input  logic                   in_wr,
   output logic                   in_rdy,
   input  logic [DEPTH-1:0]       stall_req,
   input  logic                   flush_en,
   input  logic [SELW-1:0]        flush_stage,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [WIDTH-1:0]       out_data,
   output logic [REGW-1:0]        out_dst,
   output logic                   out_wr,
   output logic [DEPTH-1:0]       stage_vld,
   output logic [DEPTH*WIDTH-1:0] stage_data,
   input  logic [SELW-1:0]        fwd_q_stage,
   input  logic [REGW-1:0]        fwd_reg,
   output logic                   fwd_hit,
   output logic [SELW-1:0]        fwd_sel,
   output logic [15:0]            retire_cnt
);

   logic [DEPTH-1:0] vldR;
   logic [WIDTH-1:0] dataR [DEPTH];
   logic [REGW-1:0]  dstR  [DEPTH];
   logic [DEPTH-1:0] wrR;
   logic [15:0]      retireR;

   logic [DEPTH-1:0] movS;
   logic [DEPTH-1:0] freeS;
   logic [DEPTH-1:0] killS;
   logic [DEPTH-1:0] vldNxtS;
   logic [DEPTH-1:0] matchS;
   logic [SELW-1:0]  fwdSelS;
   logic             accS;

   // Move/free chain, walked from the exit back to the entry stage.
   always_comb begin
      logic downFree;
      logic mv;
      movS     = {DEPTH{1'b0}};
      freeS    = {DEPTH{1'b0}};
      downFree = out_rdy;
      mv       = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         mv       = vldR[k] & ~stall_req[k] & downFree;
         movS[k]  = mv;
         downFree = ~stall_req[k] & (~vldR[k] | mv);
         freeS[k] = downFree;
      end
   end

   assign in_rdy = freeS[0];
   assign accS   = in_vld & freeS[0];

   // Stages whose pre-edge occupant is younger than the flush origin.
   always_comb begin
      killS = {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         killS[k] = flush_en & (SELW'(k) < flush_stage);
      end
   end

   // Next valid bits: a stage is filled by its upstream mover or by its own held token.
   always_comb begin
      vldNxtS    = {DEPTH{1'b0}};
      vldNxtS[0] = (accS & ~flush_en) | (vldR[0] & ~movS[0] & ~killS[0]);
      for (int k = 1; k < DEPTH; k++) begin
         vldNxtS[k] = (movS[k-1] & ~killS[k-1]) | (vldR[k] & ~movS[k] & ~killS[k]);
      end
   end

   // Stage state and retire counter; payload fields only load on accept or move.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vldR    <= {DEPTH{1'b0}};
         wrR     <= {DEPTH{1'b0}};
         retireR <= 16'd0;
         for (int k = 0; k < DEPTH; k++) begin
            dataR[k] <= {WIDTH{1'b0}};
            dstR[k]  <= {REGW{1'b0}};
         end
      end else begin
         vldR <= vldNxtS;
         if (movS[DEPTH-1]) begin
            retireR <= retireR + 16'd1;
         end
         if (accS) begin
            dataR[0] <= in_data;
            dstR[0]  <= in_dst;
            wrR[0]   <= in_wr;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (movS[k-1]) begin
               dataR[k] <= dataR[k-1];
               dstR[k]  <= dstR[k-1];
               wrR[k]   <= wrR[k-1];
            end
         end
      end
   end

   // Candidate forwarding sources: older, valid writers of a nonzero register.
   always_comb begin
      matchS = {DEPTH{1'b0}};
      for (int j = 0; j < DEPTH; j++) begin
         matchS[j] = (SELW'(j) > fwd_q_stage) & vldR[j] & wrR[j] &
                     (dstR[j] == fwd_reg) & (fwd_reg != {REGW{1'b0}});
      end
   end

   // Youngest matching writer wins, so scan down and let lower indices overwrite.
   always_comb begin
      fwdSelS = {SELW{1'b0}};
      for (int j = DEPTH - 1; j >= 0; j--) begin
         fwdSelS = matchS[j] ? SELW'(j) : fwdSelS;
      end
   end

   assign fwd_hit = |matchS;
   assign fwd_sel = fwdSelS;

   // Flatten stage payloads for datapath observation.
   always_comb begin
      stage_data = {(DEPTH*WIDTH){1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         stage_data[k*WIDTH +: WIDTH] = dataR[k];
      end
   end

   assign stage_vld  = vldR;
   assign out_vld    = vldR[DEPTH-1];
   assign out_data   = dataR[DEPTH-1];
   assign out_dst    = dstR[DEPTH-1];
   assign out_wr     = wrR[DEPTH-1];
   assign retire_cnt = retireR;

endmodule
